// File: rtl/pc_if.sv
// SRP16 program counter bus bundle: control strobes, data-bus input,
// address-bus and data-bus outputs, with master/slave views.
interface pc_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             read;
  logic             readplusone;
  logic             readplusfour;
  logic             write;
  logic             offset;
  logic             inc;
  logic [WIDTH-1:0] abus_out;
  logic [WIDTH-1:0] dbus_out;

  modport master (
    output din, read, readplusone, readplusfour,
    output write, offset, inc,
    input  abus_out, dbus_out
  );

  modport slave (
    input  din, read, readplusone, readplusfour,
    input  write, offset, inc,
    output abus_out, dbus_out
  );
endinterface

// File: rtl/pc.sv
// SRP16 program counter: load/offset/increment on clk, PC on abus_out,
// PC/PC+1/PC+4 on dbus_out while a read strobe is active.
// Ports (positional order is fixed for existing instantiations):
//   din          in  data-bus input (load value or offset)
//   read         in  drive PC on dbus_out
//   readplusone  in  drive PC+1 on dbus_out
//   readplusfour in  drive PC+4 on dbus_out
//   write        in  PC <= din
//   offset       in  PC <= PC + din
//   inc          in  PC <= PC + 1
//   clk          in  rising-edge clock
//   abus_out     out current PC
//   dbus_out     out read-back value
//   reset        in  synchronous, active-high
// Build option: define PC_DBUS_TRISTATE_EN to float dbus_out when idle;
// otherwise dbus_out drives zero when idle.
module pc #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             read,
  input  logic             readplusone,
  input  logic             readplusfour,
  input  logic             write,
  input  logic             offset,
  input  logic             inc,
  input  logic             clk,
  output logic [WIDTH-1:0] abus_out,
  output logic [WIDTH-1:0] dbus_out,
  input  logic             reset
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] rd_val;
  logic             rd_en;

  // Highest-priority control wins; sums wrap modulo 2^WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (write)
      pc_d = din;
    else if (offset)
      pc_d = pc_q + din;
    else if (inc)
      pc_d = pc_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_VALUE;
    else
      pc_q <= pc_d;
  end

  assign abus_out = pc_q;

  always_comb begin
    rd_val = '0;
    if (read)
      rd_val = pc_q;
    else if (readplusone)
      rd_val = pc_q + WIDTH'(1);
    else if (readplusfour)
      rd_val = pc_q + WIDTH'(4);
  end

  assign rd_en = read | readplusone | readplusfour;

`ifdef PC_DBUS_TRISTATE_EN
  assign dbus_out = rd_en ? rd_val : {WIDTH{1'bz}};
`else
  assign dbus_out = rd_en ? rd_val : '0;
`endif

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for the SRP16 program counter.
// Each scenario task drives the bus bundle and checks inline.
module tb_pc;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

`ifdef PC_DBUS_TRISTATE_EN
  localparam logic [W-1:0] IDLE = {W{1'bz}};
`else
  localparam logic [W-1:0] IDLE = '0;
`endif

  pc_if #(.WIDTH(W)) bus ();

  pc #(
    .WIDTH(W),
    .RESET_VALUE(16'h0000)
  ) dut (
    .din         (bus.din),
    .read        (bus.read),
    .readplusone (bus.readplusone),
    .readplusfour(bus.readplusfour),
    .write       (bus.write),
    .offset      (bus.offset),
    .inc         (bus.inc),
    .clk         (clk),
    .abus_out    (bus.abus_out),
    .dbus_out    (bus.dbus_out),
    .reset       (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.din   = v;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_abus got %h want %h", bus.abus_out, 16'h0000);
    end
    n_run++;
    if (bus.dbus_out !== IDLE) begin
      n_fail++;
      $display("FAIL reset_dbus_idle got %h want %h", bus.dbus_out, IDLE);
    end
  endtask

  task automatic test_load();
    load(16'h0F0F);
    bus.read = 1'b1;
    #1;
    n_run++;
    if (bus.abus_out !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL load_abus got %h want %h", bus.abus_out, 16'h0F0F);
    end
    n_run++;
    if (bus.dbus_out !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL load_dbus got %h want %h", bus.dbus_out, 16'h0F0F);
    end
    bus.read = 1'b0;
  endtask

  task automatic test_inc_offset();
    bus.inc = 1'b1;
    tick();
    bus.inc = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h0F10) begin
      n_fail++;
      $display("FAIL inc got %h want %h", bus.abus_out, 16'h0F10);
    end
    bus.din    = 16'h0301;
    bus.offset = 1'b1;
    tick();
    bus.offset = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h1211) begin
      n_fail++;
      $display("FAIL offset got %h want %h", bus.abus_out, 16'h1211);
    end
  endtask

  task automatic test_reads();
    bus.read = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h1211) begin
      n_fail++;
      $display("FAIL read_pc got %h want %h", bus.dbus_out, 16'h1211);
    end
    bus.read        = 1'b0;
    bus.readplusone = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h1212) begin
      n_fail++;
      $display("FAIL read_pc1 got %h want %h", bus.dbus_out, 16'h1212);
    end
    bus.readplusone  = 1'b0;
    bus.readplusfour = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h1215) begin
      n_fail++;
      $display("FAIL read_pc4 got %h want %h", bus.dbus_out, 16'h1215);
    end
    bus.readplusfour = 1'b0;
    #1;
    n_run++;
    if (bus.dbus_out !== IDLE) begin
      n_fail++;
      $display("FAIL read_idle got %h want %h", bus.dbus_out, IDLE);
    end
    tick();
    n_run++;
    if (bus.abus_out !== 16'h1211) begin
      n_fail++;
      $display("FAIL read_no_side_effect got %h want %h",
               bus.abus_out, 16'h1211);
    end
  endtask

  task automatic test_read_during_update();
    bus.din  = 16'hABCD;
    bus.read = 1'b1;
    bus.inc  = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h1211) begin
      n_fail++;
      $display("FAIL rdupd_pre got %h want %h", bus.dbus_out, 16'h1211);
    end
    tick();
    bus.inc = 1'b0;
    n_run++;
    if (bus.dbus_out !== 16'h1212) begin
      n_fail++;
      $display("FAIL rdupd_post got %h want %h", bus.dbus_out, 16'h1212);
    end
    bus.read = 1'b0;
  endtask

  task automatic test_wrap();
    load(16'hFFFE);
    bus.readplusfour = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h0002) begin
      n_fail++;
      $display("FAIL wrap_pc4 got %h want %h", bus.dbus_out, 16'h0002);
    end
    bus.readplusfour = 1'b0;
    bus.inc = 1'b1;
    tick();
    n_run++;
    if (bus.abus_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_inc1 got %h want %h", bus.abus_out, 16'hFFFF);
    end
    tick();
    bus.inc = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_inc2 got %h want %h", bus.abus_out, 16'h0000);
    end
    load(16'h0010);
    bus.din    = 16'hFFF0;
    bus.offset = 1'b1;
    tick();
    bus.offset = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_offset got %h want %h", bus.abus_out, 16'h0000);
    end
  endtask

  task automatic test_priority();
    bus.din    = 16'h1234;
    bus.write  = 1'b1;
    bus.offset = 1'b1;
    bus.inc    = 1'b1;
    tick();
    bus.write = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL prio_write got %h want %h", bus.abus_out, 16'h1234);
    end
    // offset beats inc: 1234 + 0010
    bus.din = 16'h0010;
    tick();
    bus.offset = 1'b0;
    bus.inc    = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h1244) begin
      n_fail++;
      $display("FAIL prio_offset got %h want %h", bus.abus_out, 16'h1244);
    end
    // reset with no edge must not disturb the PC
    reset = 1'b1;
    #2;
    n_run++;
    if (bus.abus_out !== 16'h1244) begin
      n_fail++;
      $display("FAIL reset_no_edge got %h want %h", bus.abus_out, 16'h1244);
    end
    bus.din   = 16'h5555;
    bus.write = 1'b1;
    tick();
    reset     = 1'b0;
    bus.write = 1'b0;
    n_run++;
    if (bus.abus_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL prio_reset got %h want %h", bus.abus_out, 16'h0000);
    end
    load(16'h7001);
    bus.read         = 1'b1;
    bus.readplusfour = 1'b1;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h7001) begin
      n_fail++;
      $display("FAIL prio_read got %h want %h", bus.dbus_out, 16'h7001);
    end
    bus.read = 1'b0;
    #1;
    n_run++;
    if (bus.dbus_out !== 16'h7005) begin
      n_fail++;
      $display("FAIL prio_pc4_alone got %h want %h",
               bus.dbus_out, 16'h7005);
    end
    bus.readplusfour = 1'b0;
  endtask

  initial begin
    n_run            = 0;
    n_fail           = 0;
    reset            = 1'b0;
    bus.din          = '0;
    bus.read         = 1'b0;
    bus.readplusone  = 1'b0;
    bus.readplusfour = 1'b0;
    bus.write        = 1'b0;
    bus.offset       = 1'b0;
    bus.inc          = 1'b0;
    test_reset();
    test_load();
    test_inc_offset();
    test_reads();
    test_read_during_update();
    test_wrap();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc.md
Name: pc

Overview:
- 16-bit program counter register for the SRP16 CPU datapath.
- Loads an absolute value from the data bus, increments by one, or adds a relative offset, all on the clock edge.
- Always presents the current PC on the address bus.
- Can place PC, PC+1 or PC+4 on the data bus for read-back, call/return linkage and branch-target use.

Parameters:
- WIDTH, 16, bit width of the PC, din, abus_out and dbus_out.
- RESET_VALUE, 16'h0000, value loaded by reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  data-bus input: absolute load value (write) or offset (offset).
- read  input  1  drive PC onto dbus_out.
- readplusone  input  1  drive PC+1 onto dbus_out.
- readplusfour  input  1  drive PC+4 onto dbus_out.
- write  input  1  load din into PC at the next edge.
- offset  input  1  PC <= PC + din at the next edge.
- inc  input  1  PC <= PC + 1 at the next edge.
- abus_out  output  WIDTH  address bus; always equals the PC register.
- dbus_out  output  WIDTH  data-bus output, driven only while a read strobe is active.

Behaviour:
- Positional declaration order is fixed for existing instantiations: din, read, readplusone, readplusfour, write, offset, inc, clk, abus_out, dbus_out, reset.
- Clock and reset: one clock, clk; reset is synchronous and active-high.
  - reset high at a rising edge: PC <= RESET_VALUE. Reset overrides all other controls.
  - Reset asserted with no clock edge leaves PC unchanged.
- Update priority at each rising edge, with only the highest active control taking effect:
  - reset
  - write (PC <= din)
  - offset (PC <= PC + din)
  - inc (PC <= PC + 1)
  - none active: hold.
- Arithmetic:
  - All additions are unsigned modulo 2^WIDTH and wrap silently: 16'hFFFF + 1 = 16'h0000; PC + din overflow discards the carry.
  - din is treated as a full-width two's-complement value, so backward offsets are expressed as negative din.
- abus_out:
  - Combinational copy of the PC register.
  - Reflects a new value immediately after the updating edge.
  - Equals RESET_VALUE after reset.
- dbus_out:
  - Combinational, zero latency. The register value updates only at the clock edge; dbus_out reflects the current PC.
  - Read priority: read -> PC; else readplusone -> PC+1; else readplusfour -> PC+4.
  - PC+1 and PC+4 wrap modulo 2^WIDTH and do not modify the PC.
  - No read strobe active: see Optional Feature.
- Simultaneous read and update:
  - dbus_out shows the pre-edge PC until the edge, then the post-edge value.
  - No write-through from din to dbus_out.
- Reads are side-effect free; strobes may be held across many cycles.

Optional Feature:
- Macro PC_DBUS_TRISTATE_EN.
- Defined: dbus_out is high-impedance on all bits whenever read, readplusone and readplusfour are all low, for a shared tri-state data bus.
- Undefined: dbus_out drives all zeros when no read strobe is active, for mux-based bus integration.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: reset=1 with one clk edge -> abus_out = 16'h0000; with no read strobe, dbus_out = Z (feature on) or 0 (feature off).
- Load and read-back: din=16'h0F0F, write=1, one edge, then write=0 and read=1 -> abus_out = dbus_out = 16'h0F0F.
- Increment: from 16'h0F0F, inc=1, one edge -> 16'h0F10. Offset: then din=16'h0301, offset=1, one edge -> abus_out = 16'h1211.
- Read variants at PC = 16'h1211: read -> 16'h1211; readplusone -> 16'h1212; readplusfour -> 16'h1215; PC remains 16'h1211 afterwards.
- Wrap: load 16'hFFFE; readplusfour -> 16'h0002; inc twice -> 16'h0000; load 16'h0010 with offset din=16'hFFF0 -> 16'h0000.
- Priority: write=1, offset=1 and inc=1 with din=16'h1234 -> PC = 16'h1234; reset=1 with write=1 -> PC = 16'h0000; read and readplusfour both high -> dbus_out = PC.
